// File: rtl/sram_soc_responder_if.sv
// SRAM-style instruction and data master ports seen by the responder.
// master = CPU side, slave = memory/peripheral side.
interface sram_soc_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen,
        output inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        output data_sram_en, data_sram_wen,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen,
        input  inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        input  data_sram_en, data_sram_wen,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/sram_soc_responder.sv
// Shared word array behind the instruction and data SRAM ports,
// plus a config window with LED, switch, timer and compare irq.
module sram_soc_responder #(
    parameter int unsigned MEM_AW    = 16,
    parameter logic [31:0] CONF_BASE = 32'h1faf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_soc_responder_if.slave        bus,
    input  logic [7:0]                 switch,
    output logic [15:0]                led,
    output logic                       timer_irq
);
    localparam logic [9:0] SEL_LED    = 10'h000;
    localparam logic [9:0] SEL_SWITCH = 10'h001;
    localparam logic [9:0] SEL_TIMER  = 10'h002;
    localparam logic [9:0] SEL_CMP    = 10'h003;
    localparam logic [9:0] SEL_STATUS = 10'h004;

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] inst_idx;
    logic [MEM_AW-1:0] data_idx;
    logic [9:0]        reg_sel;
    logic              conf_hit;
    logic              mem_wr;
    logic              conf_wr;
    logic [31:0]       wmask;
    logic [31:0]       reg_rdata;
    logic [31:0]       timer;
    logic [31:0]       timer_cmp;
    logic              pending;
    logic              match;
    logic              led_wr;
    logic              timer_wr;
    logic              cmp_wr;
    logic              status_clr;
    logic              unused_bits;

    assign inst_idx = bus.inst_sram_addr[MEM_AW+1:2];
    assign data_idx = bus.data_sram_addr[MEM_AW+1:2];
    assign reg_sel  = bus.data_sram_addr[11:2];
    assign conf_hit = (bus.data_sram_addr & CONF_MASK) == CONF_BASE;
    assign mem_wr   = bus.data_sram_en && !conf_hit &&
                      (bus.data_sram_wen != 4'b0000);
    assign conf_wr  = bus.data_sram_en && conf_hit &&
                      (bus.data_sram_wen != 4'b0000);
    assign wmask    = {{8{bus.data_sram_wen[3]}},
                       {8{bus.data_sram_wen[2]}},
                       {8{bus.data_sram_wen[1]}},
                       {8{bus.data_sram_wen[0]}}};
    assign match     = (timer == timer_cmp) && (timer_cmp != 32'h0);
    assign timer_irq = pending;

    // The instruction port never writes; these bits are intentionally dropped.
    assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                           bus.inst_sram_addr[31:MEM_AW+2],
                           bus.inst_sram_addr[1:0],
                           bus.data_sram_addr[1:0]};

    // Config register read mux and write strobes, using pre-update values.
    always_comb begin
        reg_rdata  = 32'h0;
        led_wr     = 1'b0;
        timer_wr   = 1'b0;
        cmp_wr     = 1'b0;
        status_clr = 1'b0;
        case (reg_sel)
            SEL_LED: begin
                reg_rdata = {16'h0, led};
                led_wr    = conf_wr;
            end
            SEL_SWITCH: begin
                reg_rdata = {24'h0, switch};
            end
            SEL_TIMER: begin
                reg_rdata = timer;
                timer_wr  = conf_wr;
            end
            SEL_CMP: begin
                reg_rdata = timer_cmp;
                cmp_wr    = conf_wr;
            end
            SEL_STATUS: begin
                reg_rdata  = {31'h0, pending};
                status_clr = conf_wr && bus.data_sram_wen[0] &&
                             bus.data_sram_wdata[0];
            end
            default: begin
                reg_rdata = 32'h0;
            end
        endcase
    end

    // Byte-lane writes into the shared array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wen[b]) begin
                    mem[data_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Instruction read: array only, sees the word before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.inst_sram_rdata <= 32'h0;
        end else if (bus.inst_sram_en) begin
            bus.inst_sram_rdata <= mem[inst_idx];
        end
    end

    // Data read: register window or array, read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_sram_rdata <= 32'h0;
        end else if (bus.data_sram_en) begin
            bus.data_sram_rdata <= conf_hit ? reg_rdata : mem[data_idx];
        end
    end

    // LED register, only the low two byte lanes exist.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0;
        end else if (led_wr) begin
            led <= (led & ~wmask[15:0]) | (bus.data_sram_wdata[15:0] & wmask[15:0]);
        end
    end

    // Free-running timer; a software write replaces this cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 32'h0;
        end else if (timer_wr) begin
            timer <= (timer & ~wmask) | (bus.data_sram_wdata & wmask);
        end else begin
            timer <= timer + 32'h1;
        end
    end

    // Compare value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_cmp <= 32'h0;
        end else if (cmp_wr) begin
            timer_cmp <= (timer_cmp & ~wmask) | (bus.data_sram_wdata & wmask);
        end
    end

    // Sticky compare flag; a new match beats a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end else if (status_clr) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_soc_responder.sv
// Randomized scoreboard bench for sram_soc_responder with a
// transaction-level reference model and directed spot checks.
module tb_sram_soc_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        timer_irq;

    sram_soc_responder_if bus();

    sram_soc_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switch    (switch),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic [15:0] led;
        logic        irq;
    } exp_t;

    typedef struct {
        int          tag;
        int          field;
        logic [31:0] val;
        string       name;
    } dexp_t;

    exp_t  sq[$];
    dexp_t dq[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    pool[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 64, 128, 65535};

    logic [31:0] mem_m [int];
    logic [31:0] irdata_m = 32'h0;
    logic [31:0] drdata_m = 32'h0;
    logic [31:0] cmp_m    = 32'h0;
    logic [31:0] tval     = 32'h0;
    int          tcyc     = 0;
    logic [15:0] led_m    = 16'h0;
    logic        pend_m   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tnow(input int c);
        return tval + 32'(c - tcyc);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[17:2] = idx[15:0];
        if (a[31:16] == 16'h1faf) a[31] = ~a[31];
        return a;
    endfunction

    function automatic void chk(input string n, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endfunction

    // Effect of one posedge c on the model, from the current inputs.
    task automatic model(input int c);
        logic [31:0] t, wd, lt, a;
        logic [11:0] off;
        logic [3:0]  be;
        logic        hit, clr, m;
        int          wi;
        if (rst) begin
            irdata_m = 32'h0; drdata_m = 32'h0; led_m = 16'h0;
            tval = 32'h0; tcyc = c + 1; cmp_m = 32'h0; pend_m = 1'b0;
            return;
        end
        t   = tnow(c);
        a   = bus.data_sram_addr;
        wd  = bus.data_sram_wdata;
        be  = bus.data_sram_wen;
        hit = bus.data_sram_en && (a[31:16] == 16'h1faf);
        m   = (t == cmp_m) && (cmp_m != 32'h0);
        clr = 1'b0;
        if (bus.inst_sram_en)
            irdata_m = mem_m[int'((bus.inst_sram_addr >> 2) & 32'hffff)];
        if (hit) begin
            off = a[11:0] & 12'hffc;
            case (off)
                12'h000: drdata_m = {16'h0, led_m};
                12'h004: drdata_m = {24'h0, switch};
                12'h008: drdata_m = t;
                12'h00c: drdata_m = cmp_m;
                12'h010: drdata_m = {31'h0, pend_m};
                default: drdata_m = 32'h0;
            endcase
            if (off == 12'h000) begin
                lt = merge({16'h0, led_m}, wd, {2'b00, be[1:0]});
                led_m = lt[15:0];
            end
            if (off == 12'h008 && be != 4'h0) begin
                tval = merge(t, wd, be);
                tcyc = c + 1;
            end
            if (off == 12'h00c) cmp_m = merge(cmp_m, wd, be);
            if (off == 12'h010 && be[0] && wd[0]) clr = 1'b1;
        end else if (bus.data_sram_en) begin
            wi = int'((a >> 2) & 32'hffff);
            drdata_m = mem_m[wi];
            if (be != 4'h0) mem_m[wi] = merge(mem_m[wi], wd, be);
        end
        if (m) pend_m = 1'b1;
        else if (clr) pend_m = 1'b0;
    endtask

    task automatic step(input logic r, input logic ie, input logic [31:0] ia,
                        input logic de, input logic [3:0] dw,
                        input logic [31:0] da, input logic [31:0] dd);
        exp_t e;
        rst = r;
        bus.inst_sram_en    = ie;
        bus.inst_sram_addr  = ia;
        bus.inst_sram_wen   = 4'($urandom);
        bus.inst_sram_wdata = $urandom;
        bus.data_sram_en    = de;
        bus.data_sram_wen   = dw;
        bus.data_sram_addr  = da;
        bus.data_sram_wdata = dd;
        e.tag = cyc + 1;
        model(e.tag);
        e.irdata = irdata_m;
        e.drdata = drdata_m;
        e.led    = led_m;
        e.irq    = pend_m;
        sq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_d(input int f, input logic [31:0] v, input string n);
        dexp_t d;
        d.tag = cyc; d.field = f; d.val = v; d.name = n;
        dq.push_back(d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic dwr(input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d);
        step(1'b0, 1'b0, 32'h0, 1'b1, w, a, d);
    endtask

    task automatic drd(input logic [31:0] a);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, a, 32'h0);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin : mon
        exp_t        e;
        dexp_t       d;
        logic [31:0] act;
        while (sq.size() > 0 && sq[0].tag <= cyc) begin
            e = sq.pop_front();
            chk("sb_tag", 32'(e.tag), 32'(cyc));
            chk("inst_rdata", bus.inst_sram_rdata, e.irdata);
            chk("data_rdata", bus.data_sram_rdata, e.drdata);
            chk("led", {16'h0, led}, {16'h0, e.led});
            chk("timer_irq", {31'h0, timer_irq}, {31'h0, e.irq});
        end
        while (dq.size() > 0 && dq[0].tag <= cyc) begin
            d = dq.pop_front();
            case (d.field)
                0: act = bus.inst_sram_rdata;
                1: act = bus.data_sram_rdata;
                2: act = {16'h0, led};
                default: act = {31'h0, timer_irq};
            endcase
            chk(d.name, act, d.val);
        end
    end

    initial begin : drv
        logic [31:0] v0;
        switch = 8'h0;
        rst = 1'b1;
        bus.inst_sram_en = 1'b0; bus.inst_sram_wen = 4'h0;
        bus.inst_sram_addr = 32'h0; bus.inst_sram_wdata = 32'h0;
        bus.data_sram_en = 1'b0; bus.data_sram_wen = 4'h0;
        bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;

        repeat (2) begin
            switch = 8'($urandom);
            step(1'b1, 1'($urandom), $urandom, 1'($urandom),
                 4'($urandom), $urandom, $urandom);
            expect_d(0, 32'h0, "rst_inst_rdata");
            expect_d(1, 32'h0, "rst_data_rdata");
            expect_d(2, 32'h0, "rst_led");
            expect_d(3, 32'h0, "rst_irq");
        end
        idle();
        drd(32'h1faf_0008);
        expect_d(1, 32'h1, "timer_after_rst");

        foreach (pool[i]) dwr(mem_addr(pool[i]), 4'hF, $urandom);
        v0 = mem_m[0];

        dwr(32'h0000_0100, 4'hF, 32'h1122_3344);
        dwr(32'h0000_0100, 4'b0010, 32'h0000_AA00);
        drd(32'h0000_0100);
        expect_d(1, 32'h1122_AA44, "byte_write_data");
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_d(0, 32'h1122_AA44, "byte_write_inst");

        dwr(32'h0000_0200, 4'hF, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 4'hF, 32'h0000_0200, 32'h0);
        expect_d(0, 32'hDEAD_BEEF, "collide_inst_old");
        expect_d(1, 32'hDEAD_BEEF, "collide_data_rbw");
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_d(0, 32'h0, "collide_inst_new");

        dwr(32'h1faf_0000, 4'hF, 32'h5);
        expect_d(2, 32'h5, "led_write");
        step(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_d(0, v0, "window_no_alias");
        switch = 8'hA5;
        drd(32'h1faf_0004);
        expect_d(1, 32'h0000_00A5, "switch_read");
        drd(32'h1faf_0040);
        expect_d(1, 32'h0, "hole_read");

        dwr(32'h1faf_0008, 4'hF, 32'hffff_fffe);
        dwr(32'h1faf_000c, 4'hF, 32'h1);
        drd(32'h1faf_0008);
        expect_d(1, 32'hffff_ffff, "timer_pre_wrap");
        drd(32'h1faf_0008);
        expect_d(1, 32'h0, "timer_wrap");
        expect_d(3, 32'h0, "irq_before_match");
        drd(32'h1faf_0008);
        expect_d(1, 32'h1, "timer_one");
        expect_d(3, 32'h1, "irq_rise");
        dwr(32'h1faf_0010, 4'h1, 32'h1);
        expect_d(3, 32'h0, "irq_w1c");

        dwr(32'h1faf_0008, 4'hF, 32'd100);
        dwr(32'h1faf_000c, 4'hF, 32'd102);
        idle();
        dwr(32'h1faf_0010, 4'h1, 32'h1);
        expect_d(3, 32'h1, "set_beats_clear");
        drd(32'h1faf_0010);
        expect_d(1, 32'h1, "status_sticky");
        dwr(32'h1faf_0010, 4'h1, 32'h1);
        expect_d(3, 32'h0, "irq_clear2");

        dwr(32'h1faf_0008, 4'hF, 32'h1234_5678);
        idle();
        dwr(32'h1faf_0008, 4'b0001, 32'h0000_0000);
        drd(32'h1faf_0008);
        expect_d(1, 32'h1234_5600, "timer_partial");
        drd(32'h1faf_0008);
        expect_d(1, 32'h1234_5601, "timer_resume");

        for (int n = 0; n < 1500; n++) begin
            logic        r, ie, de;
            logic [3:0]  w;
            logic [31:0] ia, da, dd;
            logic [9:0]  sel;
            int          k;
            switch = 8'($urandom);
            r  = ($urandom_range(0, 199) == 0);
            ie = 1'($urandom);
            ia = mem_addr(pool[$urandom_range(0, 10)]);
            k  = $urandom_range(0, 9);
            de = (k != 0);
            dd = $urandom;
            w  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if (k < 5) begin
                da = mem_addr(pool[$urandom_range(0, 10)]);
            end else begin
                sel = 10'($urandom_range(0, 5));
                if (sel == 10'd5) sel = 10'($urandom_range(5, 1023));
                da = {16'h1faf, 4'($urandom), sel, 2'($urandom)};
                if (sel == 10'd3 && $urandom_range(0, 1) == 1)
                    dd = tnow(cyc + 1) + $urandom_range(1, 6);
            end
            step(r, ie, ia, de, w, da, dd);
        end

        idle();
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sq.size() + dq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
